mtr_drv_multi: RTL

//  N-channel signed-duty motor driver and the successor to the 2-channel driver.
//  - Input: one signed duty per channel. Output: a DIR bit and a PWM line per channel.
//  - Adds a per-channel slew-rate limiter and a dead-time state machine on reversal.
//  - Adds saturation of the most-negative duty code and a global enable.
//  - Sits between the speed/steer controller and the H-bridge pins.

---
 rtl/mtr_pkg.sv | 25 ++
 rtl/mtr_ch.sv | 121 ++++++++++++
 rtl/mtr_drv_multi.sv | 61 ++++++
 3 files changed

// File: rtl/mtr_pkg.sv
// Shared types and helpers for the multi-channel signed-duty motor driver.
package mtr_pkg;

    // Default duty width and the magnitude field width derived from it.
    localparam int DUTY_W_DFLT = 12;
    localparam int MAG_W       = DUTY_W_DFLT - 1;

    // Per-channel drive state: normal ramping, or PWM-off dead time before a reversal.
    typedef enum logic {
        RUN  = 1'b0,
        DEAD = 1'b1
    } ch_state_t;

    // Clamp the most-negative code of a w-bit two's complement duty (carried
    // sign-extended in 32 bits) so that its magnitude fits in w-1 bits.
    function automatic logic signed [31:0] sat_duty(input logic signed [31:0] d, input int w);
        logic signed [31:0] lo;
        lo = -(32'sd1 <<< (w - 1));
        if (d == lo) begin
            return lo + 32'sd1;
        end
        return d;
    endfunction

endpackage

// File: rtl/mtr_ch.sv
// One motor channel: target register, slew limiter, RUN/DEAD reversal FSM,
// dead-time counter and the registered PWM compare.
module mtr_ch
    import mtr_pkg::*;
#(
    parameter int DUTY_W    = MAG_W + 1,
    parameter int SLEW_STEP = 16,
    parameter int DEAD_CYC  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic [DUTY_W-1:0] duty_i,
    input  logic [DUTY_W-2:0] cnt_i,
    input  logic              wrap_i,
    output logic              dir_o,
    output logic              pwm_o,
    output logic              at_tgt_o
);

    localparam int CNT_W = DUTY_W - 1;
    localparam int DC_W  = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam logic [DC_W-1:0]         DC_LOAD = DC_W'(DEAD_CYC - 1);
    localparam logic signed [DUTY_W:0]  SLEW_L  = (DUTY_W + 1)'(SLEW_STEP);

    logic signed [DUTY_W-1:0] tgt_q, tgt_d;
    logic signed [DUTY_W-1:0] app_q, app_d;
    ch_state_t                st_q, st_d;
    logic [DC_W-1:0]          dc_q, dc_d;
    logic                     dir_q, dir_d;
    logic                     pwm_q, pwm_d;

    logic signed [31:0]       duty_ext;
    logic signed [DUTY_W:0]   diff, diff_abs, step, nxt;
    logic signed [DUTY_W-1:0] slew_val;
    logic [CNT_W-1:0]         app_mag;
    logic                     tgt_neg;
    logic                     rev_req;

    assign duty_ext = {{(32 - DUTY_W){duty_i[DUTY_W-1]}}, duty_i};
    assign tgt_neg  = tgt_q[DUTY_W-1];
    // A reversal is only started from standstill, and only when the target points the other way.
    assign rev_req  = (app_q == '0) && (tgt_q != '0) && (tgt_neg != dir_q);

    // Slew step toward the target, clipped to SLEW_STEP and never crossing zero.
    always_comb begin
        diff     = (DUTY_W + 1)'(tgt_q) - (DUTY_W + 1)'(app_q);
        diff_abs = diff[DUTY_W] ? -diff : diff;
        step     = (diff_abs < SLEW_L) ? diff_abs : SLEW_L;
        if (diff[DUTY_W]) begin
            step = -step;
        end
        nxt      = (DUTY_W + 1)'(app_q) + step;
        slew_val = nxt[DUTY_W-1:0];
        if (!app_q[DUTY_W-1] && (app_q != '0) && nxt[DUTY_W]) begin
            slew_val = '0;
        end
        if (app_q[DUTY_W-1] && !nxt[DUTY_W] && (nxt != '0)) begin
            slew_val = '0;
        end
        app_mag  = CNT_W'(app_q[DUTY_W-1] ? -app_q : app_q);
    end

    // Next-state logic: enable overrides everything, then the RUN/DEAD FSM.
    always_comb begin
        tgt_d = DUTY_W'(sat_duty(duty_ext, DUTY_W));
        app_d = app_q;
        st_d  = st_q;
        dc_d  = dc_q;
        dir_d = dir_q;
        pwm_d = en_i && (st_q == RUN) && (cnt_i < app_mag);
        if (!en_i) begin
            app_d = '0;
            st_d  = RUN;
        end else begin
            case (st_q)
                RUN: begin
                    if (rev_req) begin
                        st_d = DEAD;
                        dc_d = DC_LOAD;
                    end else if (wrap_i) begin
                        app_d = slew_val;
                    end
                end
                DEAD: begin
                    if (dc_q == '0) begin
                        st_d  = RUN;
                        dir_d = tgt_neg;
                    end else begin
                        dc_d = dc_q - 1'b1;
                    end
                end
                default: st_d = RUN;
            endcase
        end
    end

    // Channel state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            tgt_q <= '0;
            app_q <= '0;
            st_q  <= RUN;
            dc_q  <= '0;
            dir_q <= 1'b0;
            pwm_q <= 1'b0;
        end else begin
            tgt_q <= tgt_d;
            app_q <= app_d;
            st_q  <= st_d;
            dc_q  <= dc_d;
            dir_q <= dir_d;
            pwm_q <= pwm_d;
        end
    end

    assign dir_o    = dir_q;
    assign pwm_o    = pwm_q;
    assign at_tgt_o = (app_q == tgt_q);

endmodule

// File: rtl/mtr_drv_multi.sv
// N-channel signed-duty motor driver: shared PWM counter and wrap pulse,
// one slew-limited channel with reversal dead time per motor.
module mtr_drv_multi
    import mtr_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int DUTY_W    = MAG_W + 1,
    parameter int SLEW_STEP = 16,
    parameter int DEAD_CYC  = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [N_CH*DUTY_W-1:0] duty,
    output logic [N_CH-1:0]        DIR,
    output logic [N_CH-1:0]        PWM,
    output logic [N_CH-1:0]        at_tgt
);

    localparam int CNT_W = DUTY_W - 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap;

    // Free-running period counter; wrap marks the last clock of each period.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
    end

    assign wrap = (cnt_q == {CNT_W{1'b1}});

    // Counter register; keeps running while disabled so channels stay phase-aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            mtr_ch #(
                .DUTY_W    (DUTY_W),
                .SLEW_STEP (SLEW_STEP),
                .DEAD_CYC  (DEAD_CYC)
            ) u_ch (
                .clk      (clk),
                .rst      (rst),
                .en_i     (en),
                .duty_i   (duty[gi*DUTY_W +: DUTY_W]),
                .cnt_i    (cnt_q),
                .wrap_i   (wrap),
                .dir_o    (DIR[gi]),
                .pwm_o    (PWM[gi]),
                .at_tgt_o (at_tgt[gi])
            );
        end
    endgenerate

endmodule
